// File: rtl/elbeth_mux_rr_n_to_1.sv
// elbeth_mux_rr_n_to_1
// N-to-1 data selector with a one-word registered output stage.
// The source channel is chosen either by the sel port (mode=0) or by a
// round-robin search that starts just after the last granted channel (mode=1).
//
// Handshake: a word moves across any valid/ready pair exactly on a rising
// edge where both valid and ready are high. in_ready is asserted only for
// the granted channel, and only when the output register is empty or being
// drained this cycle. out_valid stays high, with out_data/out_src stable,
// until the consumer takes the word with out_ready.
module elbeth_mux_rr_n_to_1 #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_IN     = 2,
    parameter int SEL_W      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic                         mode,
    input  logic [SEL_W-1:0]             sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]             out_src,
    output logic                         out_valid,
    input  logic                         out_ready
);

    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0]      r_out_src;
    logic                  r_out_valid;
    logic [SEL_W-1:0]      r_last_grant;

    logic [NUM_IN-1:0]     w_grant;
    logic                  w_found;
    logic                  w_load_ok;
    logic                  w_xfer;
    logic [SEL_W-1:0]      w_src;
    logic [DATA_WIDTH-1:0] w_data;

    // The output register can take a new word when empty or when the
    // current word leaves this cycle, which gives one word per cycle.
    assign w_load_ok = !r_out_valid || out_ready;

    // Grant selection: fixed index from sel, or the first valid channel
    // found searching upward from last_grant+1 with wrap-around.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        if (mode) begin
            for (int k = 1; k <= NUM_IN; k++) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (!w_found && (i == (int'(r_last_grant) + k) % NUM_IN) && in_valid[i]) begin
                        w_grant[i] = 1'b1;
                        w_found    = 1'b1;
                    end
                end
            end
        end else begin
            // An out-of-range sel matches no channel, so nothing is granted.
            for (int i = 0; i < NUM_IN; i++) begin
                if ((sel == SEL_W'(i)) && in_valid[i]) begin
                    w_grant[i] = 1'b1;
                end
            end
        end
    end

    // Translate the one-hot grant into a source index and the channel data.
    always_comb begin
        w_src  = '0;
        w_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) begin
                w_src  = SEL_W'(i);
                w_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign in_ready = w_grant & {NUM_IN{w_load_ok}};
    assign w_xfer   = |(in_valid & in_ready);

    // Output register and round-robin pointer; reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= '0;
            r_last_grant <= SEL_W'(NUM_IN - 1);
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= w_data;
            r_out_src    <= w_src;
            r_last_grant <= w_src;
        end else if (out_ready) begin
            // Drain with no refill: data and source keep their last values.
            r_out_valid  <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_elbeth_mux_rr_n_to_1.sv
// tb_elbeth_mux_rr_n_to_1
// Directed bench for the N-to-1 selector, NUM_IN=4, DATA_WIDTH=8, SEL_W=3.
// A word-level model (queue of words held by the output stage plus the
// round-robin pointer) is checked against the DUT on every falling edge;
// directed steps add literal expectations taken from hand-worked traces.
module tb_elbeth_mux_rr_n_to_1;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 3;

    logic            clk;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src;
    logic            out_valid;
    logic            out_ready;

    logic [W-1:0]    ch_data [N];

    assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    elbeth_mux_rr_n_to_1 #(
        .DATA_WIDTH(W),
        .NUM_IN    (N),
        .SEL_W     (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
        .out_data (out_data),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- model ----------------
    // exp_q holds {src, data} of the word the output stage should be holding.
    logic [SW+W-1:0] exp_q [$];
    logic [W-1:0]    hold_data;
    logic [SW-1:0]   hold_src;
    int              last_g;
    bit              model_live = 1'b0;

    // Which channel must win, from the arbitration rules; -1 for no grant.
    function automatic int model_pick(input logic [N-1:0] v, input logic m,
                                      input int s, input int lg);
        if (!m) return (s < N && v[s]) ? s : -1;
        for (int k = 1; k <= N; k++) begin
            if (v[(lg + k) % N]) return (lg + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int              pick;
        bit              load_ok;
        logic [N-1:0]    exp_ready;
        logic [SW+W-1:0] word;
        pick    = model_pick(in_valid, mode, int'(sel), last_g);
        load_ok = (exp_q.size() == 0) || out_ready;
        exp_ready = '0;
        if (pick >= 0 && load_ok) exp_ready[pick] = 1'b1;
        if (model_live) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("out_data", out_data, hold_data);
            chk("out_src", out_src, hold_src);
            if (!rst) chk("in_ready", in_ready, exp_ready);
        end
        if (rst) begin
            exp_q.delete();
            hold_data  = '0;
            hold_src   = '0;
            last_g     = N - 1;
            model_live = 1'b1;
        end else if (model_live) begin
            if (exp_q.size() != 0 && out_ready) begin
                word = exp_q.pop_front();
                chk("accepted_word", {out_src, out_data}, word);
            end
            if (pick >= 0 && load_ok) begin
                hold_data = ch_data[pick];
                hold_src  = SW'(pick);
                last_g    = pick;
                exp_q.push_back({hold_src, hold_data});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [N-1:0] vtab [8];

    initial begin
        vtab = '{4'b1111, 4'b0101, 4'b1000, 4'b0000, 4'b0110, 4'b1011, 4'b0001, 4'b1100};
        rst       = 1'b1;
        in_valid  = 4'b1111;
        mode      = 1'b1;
        sel       = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) ch_data[i] = 8'(8'h10 + i);

        // Reset held two cycles with every input valid.
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_src", out_src, 3'd0);

        // Round-robin streaming: 0,1,2,3,0,1 one per cycle.
        step(); chk("rr0_src", out_src, 3'd0); chk("rr0_data", out_data, 8'h10);
        step(); chk("rr1_src", out_src, 3'd1);
        step(); chk("rr2_src", out_src, 3'd2);
        step(); chk("rr3_src", out_src, 3'd3);
        step(); chk("rr4_src", out_src, 3'd0);
        step(); chk("rr5_src", out_src, 3'd1); chk("rr5_data", out_data, 8'h11);

        // Back-pressure for three cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_src", out_src, 3'd1);
            chk("bp_data", out_data, 8'h11);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_ready", in_ready, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 4'b0100);
        step(); chk("bp_next_src", out_src, 3'd2); chk("bp_next_data", out_data, 8'h12);

        // Fixed select of channel 2.
        mode       = 1'b0;
        sel        = 3'd2;
        in_valid   = 4'b0100;
        ch_data[2] = 8'hA5;
        step(); chk("fix_data", out_data, 8'hA5); chk("fix_src", out_src, 3'd2);
        sel = 3'd5;
        #1;
        chk("fix_oob_ready", in_ready, 4'b0000);
        step(); chk("fix_drain_valid", out_valid, 1'b0); chk("fix_drain_data", out_data, 8'hA5);
        step(); chk("fix_idle_valid", out_valid, 1'b0);

        // Sparse round-robin starting from last_grant=1.
        ch_data[2] = 8'h12;
        sel        = 3'd1;
        in_valid   = 4'b0010;
        step(); chk("sp_seed_src", out_src, 3'd1);
        mode     = 1'b1;
        in_valid = 4'b1001;
        step(); chk("sp0_src", out_src, 3'd3); chk("sp0_data", out_data, 8'h13);
        step(); chk("sp1_src", out_src, 3'd0);
        step(); chk("sp2_src", out_src, 3'd3);

        // Reset pulse in the middle of streaming.
        in_valid = 4'b1111;
        step(); chk("mr0_src", out_src, 3'd0);
        step(); chk("mr1_src", out_src, 3'd1);
        rst = 1'b1;
        step(); chk("mr_rst_valid", out_valid, 1'b0); chk("mr_rst_data", out_data, 8'h00);
        rst = 1'b0;
        step(); chk("mr_after_src", out_src, 3'd0); chk("mr_after_valid", out_valid, 1'b1);

        // Mixed table: changing valids, mode, sel and back-pressure mid-stream.
        for (int i = 0; i < 40; i++) begin
            in_valid        = vtab[i % 8];
            out_ready       = (i % 3) != 0;
            mode            = (i >= 20);
            sel             = SW'(i % 6);
            ch_data[i % N]  = 8'(i * 7 + 3);
            step();
        end

        in_valid  = 4'b0000;
        out_ready = 1'b1;
        step();
        step();
        chk("final_idle", out_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
